vec_issue_unit: RTL and testbench
=================================

VEC_ISSUE_UNIT -- requirements
Module: vec_issue_unit

Interface
REQ-001 Parameter WIDTH, default 4, number of vector lanes; matches the VecUnit instance fed by this block.
REQ-002 Parameter NREGS, default 8, number of vector registers (power of 2, >=2); AW = log2(NREGS).
REQ-003 clock  in  1  single clock, all state on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 ld_valid  in  1  host load strobe, unconditionally accepted.
REQ-006 ld_addr  in  AW  load destination register.
REQ-007 ld_data  in  WIDTH x shortreal  load vector.
REQ-008 instr_valid  in  1  instruction offered.
REQ-009 instr_ready  out  1  instruction accepted when valid & ready at rising edge.
REQ-010 instr_op  in  VecUnitOp_t  ADD, SUB, SCALE, ACT_SIGMOID.
REQ-011 instr_rd / instr_rs1 / instr_rs2  in  AW each  destination, source 1, source 2.
REQ-012 instr_k  in  shortreal  scalar for SCALE.
REQ-013 vu_op  out  VecUnitOp_t  to VecUnit op.
REQ-014 vu_in1 / vu_in2  out  WIDTH x shortreal  to VecUnit data_in1 / data_in2.
REQ-015 vu_inK  out  shortreal  to VecUnit data_inK.
REQ-016 vu_out  in  WIDTH x shortreal  from VecUnit data_out (combinational, valid same cycle).
REQ-017 rd_addr  in  AW; rd_data  out  WIDTH x shortreal  host read port.
REQ-018 busy  out  1  high while an issued instruction is in flight.
REQ-019 retire_count  out  16  instructions written back.

Function
REQ-020 Storage: NREGS x WIDTH shortreal registers; one issue stage S1 (valid, op, rd, in1, in2, k).
REQ-021 Accept: S1 loads op, rd, k, reg[rs1], reg[rs2]; S1.valid = 1; else S1.valid = 0.
REQ-022 Operand rules: ADD/SUB use rs1, rs2; SCALE uses rs1 and k, in2 = 0.0; ACT_SIGMOID uses rs1, in2 = 0.0, k = 0.0.
REQ-023 vu_op, vu_in1, vu_in2, vu_inK driven directly from S1 registers; all zero/ADD when S1.valid = 0.
REQ-024 Writeback: edge ending an S1.valid cycle writes vu_out into reg[S1.rd]; latency accept-to-register = 2 edges; throughput 1/cycle without hazards.
REQ-025 instr_ready = 0 when ld_valid = 1.
REQ-026 RAW stall: instr_ready = 0 when S1.valid and (rs1 == S1.rd, or op in {ADD,SUB} and rs2 == S1.rd); exactly one bubble cycle, then accept.
REQ-027 No other stall source; instr_ready otherwise 1 out of reset.
REQ-028 Load: ld_valid writes ld_data into reg[ld_addr] at the edge.
REQ-029 Load and writeback same address same edge: load data wins, writeback to that register dropped; retire_count still increments.
REQ-030 Load and writeback different addresses same edge: both written.
REQ-031 rd_data registered: updated each edge with reg[rd_addr] as it was before that edge's writes.
REQ-032 busy = S1.valid.
REQ-033 retire_count +1 per writeback edge, wraps 0xFFFF -> 0x0000.
REQ-034 rd == rs1 allowed (in-place update) and does not stall against itself.

Reset
REQ-035 reset_n low asynchronously clears all registers to 0.0, S1.valid, rd_data, retire_count, vu_* outputs (vu_op = ADD); instr_ready = 0 and busy = 0 while reset_n low.
REQ-036 Reset mid-operation discards the S1 instruction with no writeback; first accept possible at the first rising edge after reset_n rises.

Verification
REQ-037 Load r1=(1,1,0,0), r2=(6,7,8,9); ADD rd=3 rs1=1 rs2=2 -> vu_in1/vu_in2 match one cycle after accept, r3=(7,8,8,9) via rd_data, retire_count=1.
REQ-038 Back-to-back ADD r3=r1+r2 then SUB r4=r3-r2 -> instr_ready low exactly one cycle, r4=(1,1,0,0); SUB r4=r1-r2 without hazard -> no stall, r4=(-5,-6,-8,-9).
REQ-039 r1=(1,3,2,0), SCALE rd=5 rs1=1 k=-5.0 -> vu_in2=0.0, vu_inK=-5.0, r5=(-5,-15,-10,-0).
REQ-040 ld_valid to r3 with (9,9,9,9) on the writeback edge of ADD r3 -> r3=(9,9,9,9), retire_count increments, instr_ready low that cycle.
REQ-041 Assert reset_n low while S1 holds ADD r3 -> r3 stays 0.0, busy=0, retire_count=0, all vu_* zero.
REQ-042 Issue 65537 non-hazard instructions -> retire_count wraps to 1.

Source files
------------

// File: rtl/vec_issue_unit.sv
// rtl/vec_issue_unit.sv - Single-stage vector issue unit: register file, S1 issue stage, writeback from VecUnit.
// Lanes are carried as IEEE-754 single-precision bit patterns, lane 0 in the low 32 bits.
module vec_issue_unit #(
  parameter int WIDTH = 4,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS),
  localparam int DW = WIDTH * 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [31:0]   instr_k,
  output logic [1:0]    vu_op,
  output logic [DW-1:0] vu_in1,
  output logic [DW-1:0] vu_in2,
  output logic [31:0]   vu_inK,
  input  logic [DW-1:0] vu_out,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic [15:0]   retire_count
);

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_SCALE = 2'd2;

  logic [DW-1:0] regs [NREGS];

  logic          s1_valid;
  logic [1:0]    s1_op;
  logic [AW-1:0] s1_rd;
  logic [DW-1:0] s1_in1;
  logic [DW-1:0] s1_in2;
  logic [31:0]   s1_k;

  logic uses_rs2;
  logic hazard;
  logic accept;
  logic wb_en;

  assign uses_rs2    = (instr_op == OP_ADD) || (instr_op == OP_SUB);
  // rd == rs1 of the offered instruction is never a hazard; only S1's destination matters.
  assign hazard      = s1_valid && ((instr_rs1 == s1_rd) || (uses_rs2 && (instr_rs2 == s1_rd)));
  assign instr_ready = reset_n && !ld_valid && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign wb_en       = s1_valid && !(ld_valid && (ld_addr == s1_rd));

  assign vu_op  = s1_op;
  assign vu_in1 = s1_in1;
  assign vu_in2 = s1_in2;
  assign vu_inK = s1_k;
  assign busy   = s1_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s1_op        <= OP_ADD;
      s1_rd        <= '0;
      s1_in1       <= '0;
      s1_in2       <= '0;
      s1_k         <= '0;
      rd_data      <= '0;
      retire_count <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= instr_op;
        s1_rd  <= instr_rd;
        s1_in1 <= regs[instr_rs1];
        s1_in2 <= uses_rs2 ? regs[instr_rs2] : '0;
        s1_k   <= (instr_op == OP_SCALE) ? instr_k : '0;
      end else begin
        s1_op  <= OP_ADD;
        s1_rd  <= '0;
        s1_in1 <= '0;
        s1_in2 <= '0;
        s1_k   <= '0;
      end
      rd_data <= regs[rd_addr];
      if (s1_valid) begin
        retire_count <= retire_count + 16'd1;
      end
    end
  end

  // A colliding host load suppresses the writeback, so the load always lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        regs[s1_rd] <= vu_out;
      end
      if (ld_valid) begin
        regs[ld_addr] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_vec_issue_unit.sv
// tb/tb_vec_issue_unit.sv - Scoreboard bench for vec_issue_unit with a behavioural VecUnit model.
module tb_vec_issue_unit;

  localparam int DW = 128;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_SCALE = 2'd2, OP_SIG = 2'd3;
  localparam logic [31:0] F0 = 32'h0000_0000, F1 = 32'h3F80_0000, F2 = 32'h4000_0000,
                          F3 = 32'h4040_0000, F6 = 32'h40C0_0000, F7 = 32'h40E0_0000,
                          F8 = 32'h4100_0000, F9 = 32'h4110_0000, F10 = 32'h4120_0000,
                          FM0 = 32'h8000_0000, FM5 = 32'hC0A0_0000, FM6 = 32'hC0C0_0000,
                          FM8 = 32'hC100_0000, FM9 = 32'hC110_0000, FM10 = 32'hC120_0000,
                          FM15 = 32'hC170_0000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          ld_valid = 1'b0;
  logic [2:0]    ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [1:0]    instr_op = '0;
  logic [2:0]    instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [31:0]   instr_k = '0;
  logic [1:0]    vu_op;
  logic [DW-1:0] vu_in1, vu_in2, vu_out, rd_data;
  logic [31:0]   vu_inK;
  logic [2:0]    rd_addr = '0;
  logic          busy;
  logic [15:0]   retire_count;

  typedef struct packed {
    logic [1:0]    op;
    logic [2:0]    rd;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [31:0]   k;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mdl [8];
  logic [15:0]   exp_retire;
  logic          last_acc;
  int            n_checks = 0;
  int            n_errors = 0;

  vec_issue_unit #(.WIDTH(4), .NREGS(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_k(instr_k),
    .vu_op(vu_op), .vu_in1(vu_in1), .vu_in2(vu_in2), .vu_inK(vu_inK), .vu_out(vu_out),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) d = {b[31], 63'd0};
    else d = {b[31], {3'd0, b[30:23]} + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [DW-1:0] vfn(input logic [1:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [31:0] k);
    logic [DW-1:0] res;
    real x, y, r;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      x = f2r(a[i*32 +: 32]);
      y = f2r(b[i*32 +: 32]);
      case (op)
        OP_ADD:   r = x + y;
        OP_SUB:   r = x - y;
        OP_SCALE: r = x * f2r(k);
        default:  r = 1.0 / (1.0 + $exp(-x));
      endcase
      res[i*32 +: 32] = r2f(r);
    end
    return res;
  endfunction

  // Behavioural VecUnit: combinational, result valid in the same cycle.
  assign vu_out = vfn(vu_op, vu_in1, vu_in2, vu_inK);

  function automatic logic [DW-1:0] vec(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_ready();
    logic haz;
    haz = 1'b0;
    if (q.size() != 0)
      haz = (instr_rs1 == q[0].rd) ||
            (((instr_op == OP_ADD) || (instr_op == OP_SUB)) && (instr_rs2 == q[0].rd));
    return reset_n && !ld_valid && !haz;
  endfunction

  task automatic step();
    exp_t          e, n;
    logic [DW-1:0] exp_rd;
    logic          er;
    #1;
    er = exp_ready();
    check("instr_ready", 128'(instr_ready), 128'(er));
    check("busy", 128'(busy), 128'(q.size() != 0));
    exp_rd = mdl[rd_addr];
    last_acc = instr_valid && er;
    n = '0;
    if (last_acc) begin
      n.op  = instr_op;
      n.rd  = instr_rd;
      n.in1 = mdl[instr_rs1];
      n.in2 = ((instr_op == OP_ADD) || (instr_op == OP_SUB)) ? mdl[instr_rs2] : '0;
      n.k   = (instr_op == OP_SCALE) ? instr_k : '0;
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      check("vu_op", 128'(vu_op), 128'(e.op));
      check("vu_in1", vu_in1, e.in1);
      check("vu_in2", vu_in2, e.in2);
      check("vu_inK", 128'(vu_inK), 128'(e.k));
      if (!(ld_valid && (ld_addr == e.rd))) mdl[e.rd] = vfn(e.op, e.in1, e.in2, e.k);
      exp_retire = exp_retire + 16'd1;
    end
    if (ld_valid) mdl[ld_addr] = ld_data;
    if (last_acc) q.push_back(n);
    @(posedge clock);
    #1;
    check("rd_data", rd_data, exp_rd);
    check("retire_count", 128'(retire_count), 128'(exp_retire));
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] k, output int stalls);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_k = k;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_acc) break;
      stalls++;
    end
    if (!last_acc) check("issue_timeout", 128'(0), 128'(1));
    instr_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] a, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (q.size() == 0) break;
      step();
    end
    if (q.size() != 0) check("drain_timeout", 128'(0), 128'(1));
  endtask

  task automatic read_reg(input string tag, input logic [2:0] a, input logic [DW-1:0] expv);
    rd_addr = a;
    step();
    check(tag, rd_data, expv);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'(instr_ready), 128'(0));
    check("rst_retire", 128'(retire_count), 128'(0));
    check("rst_rd_data", rd_data, '0);
    check("rst_vu", {vu_in1[63:0], vu_in2[31:0], vu_inK[29:0], vu_op}, '0);
    q.delete();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    exp_retire = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int st;
    logic [15:0] r0;
    #1;
    do_reset();
    #1;
    check("ready_after_reset", 128'(instr_ready), 128'(1));

    load(3'd1, vec(F1, F1, F0, F0));
    load(3'd2, vec(F6, F7, F8, F9));
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, F0, st);
    check("add_in1", vu_in1, vec(F1, F1, F0, F0));
    check("add_in2", vu_in2, vec(F6, F7, F8, F9));
    drain();
    read_reg("add_r3", 3'd3, vec(F7, F8, F8, F9));
    check("add_retire", 128'(retire_count), 128'(1));

    issue(OP_ADD, 3'd3, 3'd1, 3'd2, F0, st);
    issue(OP_SUB, 3'd4, 3'd3, 3'd2, F0, st);
    check("raw_stall_cycles", 128'(st), 128'(1));
    drain();
    read_reg("sub_r4_dep", 3'd4, vec(F1, F1, F0, F0));
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, F0, st);
    issue(OP_SUB, 3'd4, 3'd1, 3'd2, F0, st);
    check("nohaz_stall_cycles", 128'(st), 128'(0));
    drain();
    read_reg("sub_r4", 3'd4, vec(FM5, FM6, FM8, FM9));

    load(3'd1, vec(F1, F3, F2, F0));
    issue(OP_SCALE, 3'd5, 3'd1, 3'd2, FM5, st);
    check("scale_in2", vu_in2, '0);
    check("scale_ink", 128'(vu_inK), 128'(FM5));
    drain();
    read_reg("scale_r5", 3'd5, vec(FM5, FM15, FM10, FM0));

    issue(OP_SIG, 3'd6, 3'd1, 3'd2, F7, st);
    check("sig_in2_k", {vu_in2, vu_inK}, '0);
    drain();
    read_reg("sig_r6", 3'd6, mdl[6]);

    issue(OP_ADD, 3'd1, 3'd1, 3'd2, F0, st);
    issue(OP_ADD, 3'd7, 3'd2, 3'd2, F0, st);
    check("inplace_stall", 128'(st), 128'(0));
    drain();
    read_reg("inplace_r1", 3'd1, vec(F7, F10, F10, F9));

    load(3'd1, vec(F1, F3, F2, F0));
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, F0, st);
    r0 = retire_count;
    ld_valid = 1'b1; ld_addr = 3'd3; ld_data = vec(F9, F9, F9, F9);
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd0; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    #1;
    check("ld_blocks_ready", 128'(instr_ready), 128'(0));
    step();
    ld_valid = 1'b0; instr_valid = 1'b0;
    check("collide_retire", 128'(retire_count), 128'(r0 + 16'd1));
    read_reg("collide_r3", 3'd3, vec(F9, F9, F9, F9));

    issue(OP_ADD, 3'd4, 3'd1, 3'd2, F0, st);
    load(3'd6, vec(F2, F2, F2, F2));
    read_reg("both_r4", 3'd4, vec(F7, F10, F10, F9));
    read_reg("both_r6", 3'd6, vec(F2, F2, F2, F2));

    load(3'd3, vec(F1, F1, F1, F1));
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, F0, st);
    do_reset();
    read_reg("reset_r3", 3'd3, '0);
    issue(OP_ADD, 3'd5, 3'd1, 3'd2, F0, st);
    check("first_accept_after_reset", 128'(st), 128'(0));
    drain();

    do_reset();
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd5; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    for (int i = 0; i < 65537; i++) step();
    instr_valid = 1'b0;
    drain();
    check("retire_wrap", 128'(retire_count), 128'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
